// File: rtl/mpsoc_ahb3_req_master.sv
// Single-outstanding AHB3-Lite initiator: a valid/ready request becomes one SINGLE
// transfer on the bus and comes back as a valid/ready response. Bad size/alignment never reaches the bus.
module mpsoc_ahb3_req_master #(
    parameter int         PLEN      = 32,
    parameter int         XLEN      = 32,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic [PLEN-1:0] req_addr,
    input  logic            req_write,
    input  logic [2:0]      req_size,
    input  logic [XLEN-1:0] req_wdata,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,

    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic [XLEN-1:0] HRDATA,
    input  logic            HREADY,
    input  logic            HRESP
);
    localparam logic [2:0] MAX_SIZE      = (XLEN == 64) ? 3'd3 : 3'd2;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t          state;
    logic [XLEN-1:0] wdata_q;
    logic [PLEN-1:0] align_mask;
    logic            local_err;

    assign align_mask = (PLEN'(1) << req_size) - PLEN'(1);
    assign local_err  = (req_size > MAX_SIZE) || ((req_addr & align_mask) != '0);

    // Gated by rst so nothing is accepted in the cycle the reset is being applied.
    assign req_ready  = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wdata_q   <= '0;
            HSEL      <= 1'b0;
            HADDR     <= '0;
            HWDATA    <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= 3'd0;
            HBURST    <= HBURST_SINGLE;
            HPROT     <= 4'd0;
            HTRANS    <= HTRANS_IDLE;
            HMASTLOCK <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wdata_q <= req_wdata;
                        if (local_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end else begin
                            HSEL   <= 1'b1;
                            HTRANS <= HTRANS_NONSEQ;
                            HADDR  <= req_addr;
                            HWRITE <= req_write;
                            HSIZE  <= req_size;
                            HPROT  <= HPROT_VAL;
                            state  <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    // Address phase signals stay frozen until the slave takes them.
                    if (HREADY) begin
                        HSEL   <= 1'b0;
                        HTRANS <= HTRANS_IDLE;
                        HWDATA <= wdata_q;
                        state  <= DATA;
                    end
                end
                DATA: begin
                    // First ERROR cycle has HREADY low; the bus is already idle, so just wait it out.
                    if (HREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= HRESP;
                        rsp_rdata <= (!HWRITE && !HRESP) ? HRDATA : '0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mpsoc_ahb3_req_master.sv
// Bench for mpsoc_ahb3_req_master: scripted slave plus a transaction-timeline model
// that predicts every output each cycle; directed cases pin the model with literal values.
module tb_mpsoc_ahb3_req_master;
    localparam int         PLEN      = 32;
    localparam int         XLEN      = 32;
    localparam logic [3:0] HPROT_VAL = 4'b0011;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [PLEN-1:0] req_addr = '0;
    logic [2:0]      req_size = 3'd0;
    logic [XLEN-1:0] req_wdata = '0;
    logic            rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [XLEN-1:0] rsp_rdata;
    logic            HSEL, HWRITE, HMASTLOCK;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA, HRDATA = '0;
    logic [2:0]      HSIZE, HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HREADY = 1'b1, HRESP = 1'b0;

    mpsoc_ahb3_req_master #(.PLEN(PLEN), .XLEN(XLEN), .HPROT_VAL(HPROT_VAL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0;

    // staged stimulus, applied right after each cycle's sample
    logic            s_rst = 1'b1, s_valid = 1'b0, s_write = 1'b0, s_rsp_ready = 1'b0;
    logic [PLEN-1:0] s_addr = '0;
    logic [2:0]      s_size = 3'd0;
    logic [XLEN-1:0] s_wdata = '0;
    int              k_aw = 0, k_dw = 0;
    bit              k_berr = 0;

    // transaction-level model
    bit              busy = 0, lerr = 0, berr = 0, m_write = 0, reset_next = 1;
    int              t_hs = 0, aw = 0, dw = 0, rsp_start = 0;
    logic [PLEN-1:0] m_addr = '0, last_haddr = '0;
    logic [XLEN-1:0] m_wdata = '0, exp_rdata = '0;
    logic [2:0]      last_hsize = 3'd0;
    bit              last_hwrite = 0, exp_err = 0;
    bit [XLEN-1:0]   mem [int];

    // observations for the directed literal checks
    bit              hs_flag = 0, done_flag = 0;
    int              obs_rsp_cyc = -1, obs_ns = 0, obs_vcnt = 0;
    logic [XLEN-1:0] obs_rdata = '0, obs_hwd = '0;
    logic            obs_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit [XLEN-1:0] mem_rd(input logic [PLEN-1:0] a);
        int k = int'(a >> 2);
        return mem.exists(k) ? mem[k] : '0;
    endfunction

    task automatic check_cycle();
        bit e_ns, e_dp, e_rv, e_rr;
        e_ns = busy && !lerr && cyc >= t_hs + 1 && cyc <= t_hs + 1 + aw;
        e_dp = busy && !lerr && cyc >= t_hs + 2 + aw && cyc <= t_hs + 2 + aw + dw;
        e_rv = busy && cyc >= rsp_start;
        e_rr = !busy && !rst;
        chk("req_ready", req_ready, e_rr);
        chk("htrans", HTRANS, e_ns ? 2 : 0);
        chk("hsel", HSEL, e_ns);
        chk("hburst", HBURST, 0);
        chk("hmastlock", HMASTLOCK, 0);
        chk("haddr", HADDR, last_haddr);
        chk("hwrite", HWRITE, last_hwrite);
        chk("hsize", HSIZE, last_hsize);
        if (e_ns) chk("hprot", HPROT, HPROT_VAL);
        if (e_dp) chk("hwdata", HWDATA, m_wdata);
        chk("rsp_valid", rsp_valid, e_rv);
        if (e_rv) begin
            chk("rsp_err", rsp_err, exp_err);
            chk("rsp_rdata", rsp_rdata, exp_rdata);
        end
        if (reset_next) begin
            chk("rst_hprot", HPROT, 0);
            chk("rst_hwdata", HWDATA, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
        end
        if (busy) begin
            if (HTRANS == 2'b10) obs_ns++;
            if (rsp_valid) begin
                obs_vcnt++;
                if (obs_rsp_cyc < 0) obs_rsp_cyc = cyc;
                obs_rdata = rsp_rdata;
                obs_err   = rsp_err;
            end
            if (cyc == t_hs + 2) obs_hwd = HWDATA;
        end
    endtask

    task automatic drive_cycle();
        rst = s_rst; req_valid = s_valid; req_addr = s_addr; req_write = s_write;
        req_size = s_size; req_wdata = s_wdata; rsp_ready = s_rsp_ready;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
        if (busy && !lerr) begin
            if (cyc >= t_hs + 1 && cyc <= t_hs + 1 + aw)
                HREADY = (cyc == t_hs + 1 + aw);
            else if (cyc >= t_hs + 2 + aw && cyc <= t_hs + 2 + aw + dw) begin
                HREADY = (cyc == t_hs + 2 + aw + dw);
                HRESP  = berr && (cyc >= t_hs + 1 + aw + dw);
                if (HREADY && !berr && !m_write) HRDATA = mem_rd(m_addr);
            end
        end
    endtask

    task automatic model_update();
        if (rst) begin
            busy = 0; last_haddr = '0; last_hwrite = 0; last_hsize = 3'd0; reset_next = 1;
        end else begin
            reset_next = 0;
            if (busy) begin
                if (!lerr && m_write && !berr && cyc == t_hs + 2 + aw + dw)
                    mem[int'(m_addr >> 2)] = m_wdata;
                if (cyc >= rsp_start && rsp_ready) begin
                    busy = 0; done_flag = 1;
                end
            end else if (req_valid) begin
                busy = 1; hs_flag = 1; t_hs = cyc;
                m_addr = req_addr; m_write = req_write; m_wdata = req_wdata;
                lerr = (req_size > 3'd2) || (req_addr % (32'd1 << req_size) != 0);
                aw = k_aw; dw = k_dw; berr = k_berr && !lerr;
                rsp_start = lerr ? cyc + 1 : cyc + 3 + aw + dw;
                exp_err   = lerr || berr;
                exp_rdata = (!m_write && !exp_err) ? mem_rd(m_addr) : '0;
                if (!lerr) begin
                    last_haddr = req_addr; last_hwrite = req_write; last_hsize = req_size;
                end
                obs_rsp_cyc = -1; obs_ns = 0; obs_vcnt = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        drive_cycle();
        model_update();
        cyc++;
    endtask

    // rr_hold < 0: random response backpressure; otherwise hold rsp_ready low that many valid cycles
    task automatic txn(input logic [PLEN-1:0] a, input bit w, input logic [2:0] s,
                       input logic [XLEN-1:0] wd, input int kaw, input int kdw,
                       input bit kberr, input int rr_hold);
        int guard;
        k_aw = kaw; k_dw = kdw; k_berr = kberr;
        s_valid = 1'b1; s_addr = a; s_write = w; s_size = s; s_wdata = wd; s_rsp_ready = 1'b0;
        hs_flag = 0; guard = 0;
        while (!hs_flag && guard < 20) begin step(); guard++; end
        chk("hs_timeout", hs_flag, 1);
        done_flag = 0; guard = 0;
        while (hs_flag && !done_flag && guard < 60) begin
            s_valid = 1'($urandom_range(0, 1)); s_addr = $urandom; s_write = 1'($urandom_range(0, 1));
            s_size = 3'($urandom_range(0, 7)); s_wdata = $urandom;
            if (rr_hold < 0) s_rsp_ready = 1'($urandom_range(0, 1));
            else             s_rsp_ready = (cyc >= rsp_start) && (cyc - rsp_start >= rr_hold);
            step(); guard++;
        end
        if (hs_flag) chk("rsp_timeout", done_flag, 1);
        s_valid = 1'b0; s_rsp_ready = 1'b0;
    endtask

    initial begin
        int gap, off;
        logic [2:0] sz;
        repeat (2) @(posedge clk);
        step(); step();
        s_rst = 1'b0;
        step();

        txn(32'h10, 1, 3'd2, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("wr_latency", obs_rsp_cyc - t_hs, 3);
        chk("wr_nonseq", obs_ns, 1);
        chk("wr_hwdata", obs_hwd, 32'hDEADBEEF);
        chk("wr_err", obs_err, 0);
        txn(32'h10, 0, 3'd2, 32'h0, 0, 0, 0, 0);
        chk("rd_rdata", obs_rdata, 32'hDEADBEEF);
        chk("rd_latency", obs_rsp_cyc - t_hs, 3);

        txn(32'h14, 1, 3'd2, 32'h12345678, 0, 3, 0, 0);
        chk("dwait_latency", obs_rsp_cyc - t_hs, 6);
        txn(32'h18, 0, 3'd2, 32'h0, 2, 0, 0, 0);
        chk("await_nonseq", obs_ns, 3);
        chk("await_latency", obs_rsp_cyc - t_hs, 5);

        txn(32'h40, 0, 3'd2, 32'h0, 0, 1, 1, 0);
        chk("berr_err", obs_err, 1);
        chk("berr_rdata", obs_rdata, 0);
        chk("berr_nonseq", obs_ns, 1);

        txn(32'h13, 0, 3'd1, 32'h0, 0, 0, 0, 0);
        chk("lerr_half_err", obs_err, 1); chk("lerr_half_nonseq", obs_ns, 0);
        chk("lerr_half_latency", obs_rsp_cyc - t_hs, 1);
        txn(32'h10, 1, 3'd3, 32'h55AA55AA, 0, 0, 0, 0);
        chk("lerr_dword_err", obs_err, 1); chk("lerr_dword_nonseq", obs_ns, 0);
        chk("lerr_dword_latency", obs_rsp_cyc - t_hs, 1);
        txn(32'h02, 0, 3'd2, 32'h0, 0, 0, 0, 0);
        chk("lerr_word_err", obs_err, 1); chk("lerr_word_nonseq", obs_ns, 0);
        chk("lerr_word_latency", obs_rsp_cyc - t_hs, 1);

        txn(32'h10, 0, 3'd2, 32'h0, 0, 0, 0, 5);
        chk("bp_rdata", obs_rdata, 32'hDEADBEEF);
        chk("bp_valid_cycles", obs_vcnt, 6);
        chk("bp_nonseq", obs_ns, 1);

        // reset during a data-phase wait state
        k_aw = 0; k_dw = 3; k_berr = 0;
        s_valid = 1'b1; s_addr = 32'h30; s_write = 1'b1; s_size = 3'd2; s_wdata = 32'hCAFEF00D;
        hs_flag = 0;
        for (int g = 0; g < 20 && !hs_flag; g++) step();
        chk("mrst_hs", hs_flag, 1);
        s_valid = 1'b0;
        step(); step();
        s_rst = 1'b1; step();
        s_rst = 1'b0; step();
        chk("mrst_htrans", HTRANS, 0);
        chk("mrst_hsel", HSEL, 0);
        chk("mrst_rsp_valid", rsp_valid, 0);
        chk("mrst_haddr", HADDR, 0);
        step();
        chk("mrst_req_ready", req_ready, 1);
        txn(32'h20, 1, 3'd2, 32'hA5A5F00F, 0, 0, 0, 0);
        chk("post_rst_latency", obs_rsp_cyc - t_hs, 3);
        chk("post_rst_err", obs_err, 0);
        txn(32'h20, 0, 3'd2, 32'h0, 0, 0, 0, 0);
        chk("post_rst_rdata", obs_rdata, 32'hA5A5F00F);

        for (int i = 0; i < 250; i++) begin
            sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            off = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            dw  = 0;
            k_dw = $urandom_range(0, 3);
            txn(32'($urandom_range(0, 63) * 4 + off), 1'($urandom_range(0, 1)), sz, $urandom,
                $urandom_range(0, 2), k_dw, (k_dw > 0) && ($urandom_range(0, 5) == 0), -1);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end
endmodule
